// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 execution scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package chip8_pkg;

  localparam int FRAME_CYCLES_DEFAULT    = 16666;
  localparam int INSTR_PER_FRAME_DEFAULT = 10;
  localparam int TIMER_W                 = 8;

  // RUN: steps may be offered; WAIT_FRAME: budget spent, idle until the next frame.
  typedef enum logic {
    RUN        = 1'b0,
    WAIT_FRAME = 1'b1
  } sched_state_t;

endpackage

// File: rtl/chip8_down_timer.sv
// Loadable 8-bit saturating down-counter used for the DT and ST timers.
// Latency: load/decrement visible one cycle after the edge that samples we/dec.
// Backpressure: none; a load on the same edge as a decrement wins.
module chip8_down_timer
  import chip8_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               dec,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] value
);

  // Load has priority; decrement stops at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (we) begin
      value <= wdata;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/chip8_exec_scheduler.sv
// Paces CPU instruction steps against a fixed frame cadence and owns the DT/ST timers.
// Latency: step_valid is combinational from registered state; frame_tick is a registered 1-cycle pulse.
// Backpressure: step_valid holds until step_ready handshakes it (or pause rises); stalls once the frame budget is spent.
// Optional: define CHIP8_VBLANK_WAIT_EN to make a DXYN draw end the frame's stepping.
module chip8_exec_scheduler
  import chip8_pkg::*;
#(
  parameter int FRAME_CYCLES    = FRAME_CYCLES_DEFAULT,
  parameter int INSTR_PER_FRAME = INSTR_PER_FRAME_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause,
  output logic               step_valid,
  input  logic               step_ready,
  input  logic               draw_req,
  input  logic               dt_we,
  input  logic               st_we,
  input  logic [TIMER_W-1:0] timer_wdata,
  output logic [TIMER_W-1:0] dt_value,
  output logic               sound_on,
  output logic               frame_tick,
  output logic [15:0]        frame_count
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int BW = $clog2(INSTR_PER_FRAME + 1);
  localparam logic [CW-1:0] CYC_LAST    = CW'(FRAME_CYCLES - 1);
  localparam logic [BW-1:0] BUDGET_FULL = BW'(INSTR_PER_FRAME);
  localparam logic [BW-1:0] BUDGET_ONE  = BW'(1);

  logic [CW-1:0]      cyc_cnt;
  logic [BW-1:0]      budget;
  sched_state_t       state;
  logic               handshake;
  logic               draw_stall;
  logic               timer_dec;
  logic [TIMER_W-1:0] st_value;

  // Offer a step only from registered state; reset masks it so nothing is consumed mid-reset.
  assign step_valid = !reset && (state == RUN) && !pause && (budget != '0);
  assign handshake  = step_valid && step_ready;

`ifdef CHIP8_VBLANK_WAIT_EN
  assign draw_stall = handshake && draw_req;
`else
  // draw_req is deliberately ignored in this build; only budget exhaustion stalls.
  assign draw_stall = 1'b0 && draw_req;
`endif

  // Frame prescaler, tick pulse and frame counter; free-running even while paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt     <= '0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      cyc_cnt     <= (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + 1'b1;
      frame_tick  <= (cyc_cnt == CYC_LAST);
      frame_count <= frame_count + 16'(frame_tick);
    end
  end

  // Budget/state: a tick refills (discarding leftovers); a same-edge step is charged to the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      budget <= BUDGET_FULL;
    end else if (frame_tick) begin
      if (handshake) begin
        budget <= draw_stall ? '0 : BUDGET_FULL - 1'b1;
        state  <= (draw_stall || (BUDGET_FULL == BUDGET_ONE)) ? WAIT_FRAME : RUN;
      end else begin
        budget <= BUDGET_FULL;
        state  <= RUN;
      end
    end else if (handshake) begin
      if (draw_stall || (budget == BUDGET_ONE)) begin
        budget <= '0;
        state  <= WAIT_FRAME;
      end else begin
        budget <= budget - 1'b1;
      end
    end
  end

  // Timers count down once per frame unless paused; loads are always accepted.
  assign timer_dec = frame_tick && !pause;

  chip8_down_timer u_dt (
    .clk   (clk),
    .reset (reset),
    .we    (dt_we),
    .dec   (timer_dec),
    .wdata (timer_wdata),
    .value (dt_value)
  );

  chip8_down_timer u_st (
    .clk   (clk),
    .reset (reset),
    .we    (st_we),
    .dec   (timer_dec),
    .wdata (timer_wdata),
    .value (st_value)
  );

  assign sound_on = (st_value != '0);

endmodule

// File: tb/tb_chip8_exec_scheduler.sv
// Scoreboard bench for chip8_exec_scheduler (FRAME_CYCLES=100, INSTR_PER_FRAME=4, plus a default-size instance).
// Stimulus pushes expected handshake cycles and tick records; a negedge monitor pops and compares.
// Cycle N is the interval after the Nth rising edge following reset release (cycle 0 = first cycle out of reset).
module tb_chip8_exec_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       step_ready = 1'b0;
  logic       draw_req = 1'b0;
  logic       dt_we = 1'b0;
  logic       st_we = 1'b0;
  logic [7:0] timer_wdata = 8'h00;
  logic       step_valid;
  logic [7:0] dt_value;
  logic       sound_on;
  logic       frame_tick;
  logic [15:0] frame_count;

  logic       big_step_valid;
  logic [7:0] big_dt_value;
  logic       big_sound_on;
  logic       big_tick;
  logic [15:0] big_frame_count;

  always #5 clk = ~clk;

  chip8_exec_scheduler #(.FRAME_CYCLES(100), .INSTR_PER_FRAME(4)) dut (
    .clk(clk), .reset(reset), .pause(pause), .step_valid(step_valid),
    .step_ready(step_ready), .draw_req(draw_req), .dt_we(dt_we), .st_we(st_we),
    .timer_wdata(timer_wdata), .dt_value(dt_value), .sound_on(sound_on),
    .frame_tick(frame_tick), .frame_count(frame_count)
  );

  chip8_exec_scheduler u_big (
    .clk(clk), .reset(reset), .pause(1'b0), .step_valid(big_step_valid),
    .step_ready(1'b0), .draw_req(1'b0), .dt_we(1'b0), .st_we(1'b0),
    .timer_wdata(8'h00), .dt_value(big_dt_value), .sound_on(big_sound_on),
    .frame_tick(big_tick), .frame_count(big_frame_count)
  );

  typedef struct {
    int cyc;
    int fc;
    int dt;
  } tick_t;

  int    cyc;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b1;
  int    hs_q[$];
  tick_t tick_q[$];
  tick_t pend;
  bit    tick_pend = 1'b0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_hs(input int c);
    hs_q.push_back(c);
  endtask

  task automatic push_hs_run(input int first, input int n);
    for (int i = 0; i < n; i++) hs_q.push_back(first + i);
  endtask

  task automatic push_tick(input int c, input int fc, input int dt);
    tick_t t;
    t.cyc = c; t.fc = fc; t.dt = dt;
    tick_q.push_back(t);
  endtask

  // Caller is always just after a rising edge; advance until that cycle begins.
  task automatic goto(input int n);
    int guard = 0;
    while (cyc != n && guard < 60000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc != n) begin
      $display("FAIL goto: got cycle %0d expected %0d", cyc, n);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "cycle wait expired");
    end
  endtask

  task automatic end_check();
    chk("hs_left", hs_q.size(), 0);
    chk("tick_left", tick_q.size(), 0);
  endtask

  // Assert reset now (just after an edge), check reset state, release for cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_step_valid", step_valid, 0);
    @(posedge clk); #1;
    chk("rst_step_valid2", step_valid, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_dt", dt_value, 0);
    chk("rst_sound", sound_on, 0);
    hs_q.delete();
    tick_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: every handshake and every tick must match the head of its queue.
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      tick_pend = 1'b0;
    end else begin
      if (tick_pend) begin
        chk("frame_count_after_tick", frame_count, pend.fc);
        chk("dt_after_tick", dt_value, pend.dt);
        tick_pend = 1'b0;
      end
      if (step_valid && step_ready) begin
        if (hs_q.size() == 0) chk("hs_unexpected_cycle", cyc, -1);
        else                  chk("hs_cycle", cyc, hs_q.pop_front());
      end
      if (frame_tick) begin
        if (tick_q.size() == 0) begin
          chk("tick_unexpected_cycle", cyc, -1);
        end else begin
          pend = tick_q.pop_front();
          chk("tick_cycle", cyc, pend.cyc);
          tick_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;

    // Free-running steps: 4 per frame, stall until each tick.
    step_ready = 1'b1;
    do_reset();
    push_hs_run(0, 4); push_hs_run(101, 4); push_hs_run(201, 4);
    push_tick(100, 1, 0); push_tick(200, 2, 0);
    goto(210);
    end_check();

    // Timer loads and per-frame countdown; dual load.
    step_ready = 1'b0;
    do_reset();
    push_tick(100, 1, 2); push_tick(200, 2, 1); push_tick(300, 3, 0);
    push_tick(400, 4, 0); push_tick(500, 5, 8'h21);
    goto(10);  dt_we = 1'b1; timer_wdata = 8'h03;
    goto(11);  dt_we = 1'b0; st_we = 1'b1; timer_wdata = 8'h01;
    goto(12);  st_we = 1'b0;
    chk("dt_loaded", dt_value, 3);
    chk("sound_after_load", sound_on, 1);
    goto(99);  chk("sound_before_tick", sound_on, 1);
    goto(101); chk("sound_after_tick", sound_on, 0);
    goto(450); dt_we = 1'b1; st_we = 1'b1; timer_wdata = 8'h22;
    goto(451); dt_we = 1'b0; st_we = 1'b0;
    chk("dual_load_dt", dt_value, 8'h22);
    chk("dual_load_sound", sound_on, 1);
    goto(505);
    end_check();

    // Load on the tick edge wins over decrement; late-starting steps.
    step_ready = 1'b0;
    do_reset();
    push_hs_run(30, 4); push_hs_run(101, 4); push_hs_run(201, 4);
    push_tick(100, 1, 5); push_tick(200, 2, 4);
    goto(20);  dt_we = 1'b1; timer_wdata = 8'h02;
    goto(21);  dt_we = 1'b0;
    goto(30);  step_ready = 1'b1;
    goto(100); dt_we = 1'b1; timer_wdata = 8'h05;
    goto(101); dt_we = 1'b0;
    goto(206);
    end_check();

    // Pause across two ticks: no steps, DT frozen, frames still counted.
    step_ready = 1'b1;
    do_reset();
    push_hs_run(0, 4); push_hs_run(251, 4); push_hs_run(301, 4);
    push_tick(100, 1, 7); push_tick(200, 2, 7); push_tick(300, 3, 6);
    goto(20);  dt_we = 1'b1; timer_wdata = 8'h07;
    goto(21);  dt_we = 1'b0;
    goto(50);  pause = 1'b1;
    goto(251); pause = 1'b0;
    goto(306);
    end_check();

    // Draw on the second handshake.
    step_ready = 1'b1;
    do_reset();
`ifdef CHIP8_VBLANK_WAIT_EN
    push_hs(0); push_hs(1);
`else
    push_hs_run(0, 4);
`endif
    push_hs_run(101, 4);
    push_tick(100, 1, 0);
    goto(1);   draw_req = 1'b1;
    goto(2);   draw_req = 1'b0;
    goto(106);
    end_check();

    // Reset mid-frame with budget 1 and DT 9, a handshake pending.
    step_ready = 1'b0;
    do_reset();
    push_hs_run(10, 3);
    goto(10);  step_ready = 1'b1;
    goto(13);  step_ready = 1'b0;
    goto(20);  dt_we = 1'b1; timer_wdata = 8'h09;
    goto(21);  dt_we = 1'b0;
    goto(30);  chk("dt_before_reset", dt_value, 9);
    goto(57);  step_ready = 1'b1;
    end_check();
    do_reset();
    push_hs_run(0, 4); push_hs_run(101, 4);
    push_tick(100, 1, 0);
    goto(106);
    end_check();

    // Default-size instance: tick period 16666 from the last reset release.
    mon_en = 1'b0;
    step_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      while (!big_tick && cyc < 40000) @(negedge clk);
      chk("big_tick_cycle", cyc, 16666 * k);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_exec_scheduler.md
Name: chip8_exec_scheduler

Overview:
- Paces CPU execution against a fixed 60 Hz frame cadence.
- Owns the frame prescaler, the per-frame instruction budget, and the delay/sound timers (DT/ST).
- Sits in chip8_top between the clock and the cpu step interface; frame_tick also marks display-frame boundaries for dump and refresh logic.

Parameters:
- FRAME_CYCLES, 16666: clk cycles per frame; must be >= 2.
- INSTR_PER_FRAME, 10: instruction steps allowed per frame; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pause  in  1  freeze stepping and timers
- step_valid  out  1  CPU may execute one instruction
- step_ready  in  1  CPU accepts the step; a step is consumed when step_valid && step_ready
- draw_req  in  1  the consumed step is a DXYN draw; sampled only on a handshake
- dt_we  in  1  load DT (FX15)
- st_we  in  1  load ST (FX18)
- timer_wdata  in  8  load value for DT/ST
- dt_value  out  8  current DT (FX07)
- sound_on  out  1  ST != 0
- frame_tick  out  1  one-cycle pulse per frame
- frame_count  out  16  frames since reset; wraps modulo 2^16

Behaviour:
- Reset values: cyc_cnt=0, budget=INSTR_PER_FRAME, DT=0, ST=0, frame_tick=0, frame_count=0, state=RUN, step_valid=0 during reset.
- Prescaler:
  - cyc_cnt counts 0..FRAME_CYCLES-1, then wraps to 0.
  - frame_tick is registered and high in the cycle after cyc_cnt==FRAME_CYCLES-1.
  - First tick comes FRAME_CYCLES cycles after reset deasserts, then one every FRAME_CYCLES cycles.
  - The prescaler runs regardless of pause.
- frame_count increments on each edge where frame_tick=1.
- Budget:
  - Width is $clog2(INSTR_PER_FRAME+1).
  - Reloads to INSTR_PER_FRAME on each frame_tick edge; any unused remainder is discarded, never accumulated.
  - Decrements by 1 on each handshake.
  - If a handshake and frame_tick share an edge, next budget = INSTR_PER_FRAME-1.
- States:
  - RUN: step_valid = !pause && budget!=0. Go to WAIT_FRAME when a handshake takes budget to 0.
  - WAIT_FRAME: step_valid=0. Go to RUN on a frame_tick edge.
- step_valid:
  - Combinational from registered state/budget/pause only; never from step_ready.
  - Stays high until the handshake or until pause rises. Dropping on pause is permitted.
- Timers:
  - On a frame_tick edge with pause=0, DT and ST each decrement if nonzero and saturate at 0.
  - dt_we/st_we load timer_wdata on the edge. A load on the same edge as a decrement wins; no decrement is applied that frame.
  - dt_we and st_we together load both timers.
  - While pause=1, timers hold, but loads are still accepted.
- sound_on is combinational: ST != 0.
- Reset mid-frame: all state returns to reset values on the next edge, and any pending handshake is discarded.

Optional Feature:
- Macro: CHIP8_VBLANK_WAIT_EN.
- Defined: a handshake with draw_req=1 forces budget to 0 and state to WAIT_FRAME. No further steps occur until the next frame_tick (classic display-wait quirk).
- Undefined: draw_req is ignored; only budget exhaustion stalls the CPU.

Decomposition:
- chip8_pkg holds:
  - FRAME_CYCLES_DEFAULT=16666
  - INSTR_PER_FRAME_DEFAULT=10
  - TIMER_W=8
  - the state enum {RUN, WAIT_FRAME}
- Sub-module chip8_down_timer: 8-bit loadable, saturating down-counter with we/wdata/dec inputs. Instantiated twice (DT, ST).

Test Plan (FRAME_CYCLES=100, INSTR_PER_FRAME=4 unless noted):
- Reset released, step_ready tied 1 -> exactly 4 handshakes on cycles 0..3, then step_valid=0 until frame_tick at cycle 100; 4 more steps follow. frame_count=1 after the first tick.
- dt_we with 0x03 at cycle 10 -> dt_value reads 3, 2, 1, 0, 0 after ticks 1-4 and 5. st_we with 0x01 -> sound_on high until the first tick, then low.
- dt_we with 0x05 on the frame_tick edge -> dt_value=5 (no decrement that frame); next tick gives 4.
- pause=1 over cycles 50..250 with DT=7 -> no handshakes, DT stays 7, frame_count still reaches 2. After release, budget is 4 and DT decrements on the next tick.
- With CHIP8_VBLANK_WAIT_EN, draw_req=1 on the 2nd handshake -> no 3rd step until frame_tick, then 4 steps. Without the macro -> 4 steps that frame.
- Assert reset at cycle 57 with budget=1 and DT=9 -> next cycle: budget=4, DT=0, frame_count=0, cyc_cnt=0. FRAME_CYCLES=16666 smoke test -> tick period is 16666 cycles.
